// File: rtl/backend_pkg.sv
// Shared backend definitions: default module count and word width, the arbiter FSM
// state type, and the width helper for module-index fields.
// No logic and no ports; imported by the arbiter, its interface and rr_pick.
package backend_pkg;

  localparam int NMODULES = 4;
  localparam int LENGTH   = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; a single requester still gets 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_stream_arbiter_if.sv
// Bundle of the arbiter's per-module FIFO read ports, enable mask and output word port.
// master: arbiter side (drives in_ready/out_*/busy); slave: FIFO/GPIO/ETH side.
// Latency and backpressure are defined by the arbiter, not by this bundle.
interface rx_stream_arbiter_if #(
  parameter int NMODULES = backend_pkg::NMODULES,
  parameter int LENGTH   = backend_pkg::LENGTH
);

  localparam int IDX_W = backend_pkg::idx_width(NMODULES);

  logic [NMODULES-1:0]        enable;
  logic [NMODULES-1:0]        in_valid;
  logic [NMODULES-1:0]        in_ready;
  logic [NMODULES*LENGTH-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [LENGTH-1:0]          out_data;
  logic [IDX_W-1:0]           out_src;
  logic                       busy;

  modport master (
    input  enable, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, busy
  );

  modport slave (
    output enable, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit searching upward from last+1, wrapping.
// Purely combinational (zero latency); no handshake of its own.
// Ports: req[N] requests, last = previous winner, grant_idx = winner, any = some request set.
module rr_pick #(
  parameter int N = backend_pkg::NMODULES,
  localparam int IW = backend_pkg::idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  import backend_pkg::*;

  logic          found;
  logic [IW-1:0] idx_v;

  always_comb begin
    grant_idx = last;
    any       = |req;
    found     = 1'b0;
    idx_v     = '0;
    // k == N revisits last itself, so a lone requester keeps winning.
    for (int k = 1; k <= N; k++) begin
      idx_v = IW'((int'(last) + k) % N);
      if (!found && req[idx_v]) begin
        grant_idx = idx_v;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Round-robin arbiter merging per-module FWFT RX FIFOs into one tagged word stream.
// Latency: word handshaken at edge N is on out_* after edge N; one bubble cycle per grant.
// Backpressure: out_ready low stalls the output register and drops in_ready; grant is held.
// Ports: clk, rst (async, active high), bus (master modport: enable, in_*, out_*, busy).
module rx_stream_arbiter #(
  parameter int NMODULES  = backend_pkg::NMODULES,
  parameter int LENGTH    = backend_pkg::LENGTH,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  rx_stream_arbiter_if.master bus
);

  import backend_pkg::*;

  localparam int IDX_W = idx_width(NMODULES);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NMODULES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);

  arb_state_t          state;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [CNT_W-1:0]    burst_cnt;
  logic [NMODULES-1:0] req;
  logic                out_free;
  logic                grant_en;
  logic                grant_vld;
  logic                grant_rdy;
  logic                xfer;
  logic                release_now;
  logic [LENGTH-1:0]   grant_data;

  assign req = bus.in_valid & bus.enable;

  rr_pick #(.N(NMODULES)) u_pick (
    .req       (req),
    .last      (last_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Output register can take a word if empty or being drained this cycle.
  assign out_free   = ~bus.out_valid | bus.out_ready;
  assign grant_en   = bus.enable[grant];
  assign grant_vld  = bus.in_valid[grant];
  // Deliberately independent of in_valid: the FIFO read strobe must not loop back.
  assign grant_rdy  = (state == GRANT) & grant_en & out_free;
  assign xfer       = grant_rdy & grant_vld;
  assign grant_data = bus.in_data[int'(grant)*LENGTH +: LENGTH];

  // Leave GRANT on burst limit, requester running dry, or enable withdrawn.
  // Backpressure alone never releases (grant_rdy is low then).
  assign release_now = ~grant_en
                     | (xfer & (burst_cnt == CNT_LAST))
                     | (grant_rdy & ~grant_vld);

  always_comb begin
    bus.in_ready        = '0;
    bus.in_ready[grant] = grant_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= LAST_INIT;
      burst_cnt     <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else begin
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_src   <= grant;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            grant      <= pick_idx;
            last_grant <= pick_idx;
            burst_cnt  <= '0;
            state      <= GRANT;
            bus.busy   <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (release_now) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Scoreboard bench for rx_stream_arbiter: one instance with MAX_BURST=4, one with 16.
// Stimulus models the per-module FWFT FIFOs (word = module index in the top byte, sequence
// number in the low bits); expected words are queued up front and a negedge monitor pops them.
module tb_rx_stream_arbiter;

  import backend_pkg::*;

  localparam int NM = 4;
  localparam int LW = 128;

  typedef struct packed {
    logic [1:0]    src;
    logic [LW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rx_stream_arbiter_if #(.NMODULES(NM), .LENGTH(LW)) if4 (), if16 ();

  rx_stream_arbiter #(.NMODULES(NM), .LENGTH(LW), .MAX_BURST(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.master)
  );

  rx_stream_arbiter #(.NMODULES(NM), .LENGTH(LW), .MAX_BURST(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.master)
  );

  int          checks = 0;
  int          errors = 0;
  int          avail [NM];
  int          seq   [NM];
  bit          use4;
  logic [NM-1:0] en_act;
  logic        ordy;
  exp_t        exp_q[$];

  function automatic logic [LW-1:0] mk_word(input int m, input int s);
    return (LW'(m) << 120) | LW'(s);
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int m, input int s);
    exp_t e;
    e.src  = 2'(m);
    e.data = mk_word(m, s);
    exp_q.push_back(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NM; i++) begin
      avail[i] = 0;
      seq[i]   = 0;
    end
  endtask

  // Present the FIFO model on both instances; only the active one is enabled.
  task automatic drive();
    logic [NM-1:0]    v;
    logic [NM*LW-1:0] d;
    for (int i = 0; i < NM; i++) begin
      v[i]           = (avail[i] > 0);
      d[i*LW +: LW]  = mk_word(i, seq[i]);
    end
    if4.in_valid   = v;
    if16.in_valid  = v;
    if4.in_data    = d;
    if16.in_data   = d;
    if4.enable     = use4 ? en_act : '0;
    if16.enable    = use4 ? '0 : en_act;
    if4.out_ready  = ordy;
    if16.out_ready = ordy;
  endtask

  // One clock: sample read strobes mid-cycle, pop the FIFO model after the edge.
  task automatic step();
    logic [NM-1:0] hs;
    @(negedge clk);
    hs = (use4 ? if4.in_ready : if16.in_ready) & if16.in_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) begin
      if (hs[i]) begin
        seq[i]++;
        avail[i]--;
      end
    end
    drive();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({name, " words left"}, LW'(exp_q.size()), '0);
    exp_q.delete();
    repeat (3) step();
  endtask

  // Monitor: a word is consumed at the edge following a mid-cycle valid & ready.
  always @(negedge clk) begin
    logic          ov;
    logic [1:0]    src;
    logic [LW-1:0] dat;
    exp_t          e;
    if (!rst) begin
      ov  = use4 ? if4.out_valid : if16.out_valid;
      src = use4 ? if4.out_src   : if16.out_src;
      dat = use4 ? if4.out_data  : if16.out_data;
      if (ov && ordy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected word: got src %0d data %0h expected none", src, dat);
        end else begin
          e = exp_q.pop_front();
          chk("out_src", LW'(src), LW'(e.src));
          chk("out_data", dat, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rdy2;
    logic exp_ov;

    rst    = 1'b1;
    use4   = 1'b0;
    en_act = '0;
    ordy   = 1'b1;
    clear_model();
    drive();
    #12;
    chk("rst out_valid4", LW'(if4.out_valid), '0);
    chk("rst out_valid16", LW'(if16.out_valid), '0);
    chk("rst out_data16", if16.out_data, '0);
    chk("rst out_src16", LW'(if16.out_src), '0);
    chk("rst in_ready16", LW'(if16.in_ready), '0);
    chk("rst busy4", LW'(if4.busy), '0);
    chk("rst busy16", LW'(if16.busy), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single requester, 5 words, burst limit 16.
    use4 = 1'b0; en_act = 4'hF; ordy = 1'b1;
    clear_model();
    avail[2] = 5;
    for (int s = 0; s < 5; s++) push(2, s);
    drive();
    step();
    chk("t1 out_valid edge1", LW'(if16.out_valid), '0);
    chk("t1 busy edge1", LW'(if16.busy), 1);
    step();
    chk("t1 out_valid edge2", LW'(if16.out_valid), 1);
    chk("t1 out_src edge2", LW'(if16.out_src), 2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1 back-to-back", LW'(if16.out_valid), 1);
    end
    step();
    chk("t1 busy after 5th", LW'(if16.busy), '0);
    chk("t1 out_valid after 5th", LW'(if16.out_valid), '0);
    drain("t1", 20);

    // All modules valid, burst limit 4: 4-word bursts in order, one bubble each.
    use4 = 1'b1; en_act = 4'hF;
    clear_model();
    for (int i = 0; i < NM; i++) avail[i] = 8;
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < NM; m++)
        for (int k = 0; k < 4; k++) push(m, r*4 + k);
    drive();
    for (int k = 1; k <= 41; k++) begin
      step();
      exp_ov = (k == 1) ? 1'b0 : (((k - 2) % 5) < 4);
      chk("t2 out_valid pattern", LW'(if4.out_valid), LW'(exp_ov));
    end
    drain("t2", 20);

    // Module 0 alone, 3-cycle stall after its 4th word.
    use4 = 1'b0; en_act = 4'hF;
    clear_model();
    avail[0] = 10;
    for (int s = 0; s < 10; s++) push(0, s);
    drive();
    repeat (5) step();
    ordy = 1'b0;
    drive();
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t3 stall in_ready0", LW'(if16.in_ready[0]), '0);
      chk("t3 stall out_valid", LW'(if16.out_valid), 1);
      chk("t3 stall out_data", if16.out_data, mk_word(0, 3));
      step();
    end
    ordy = 1'b1;
    drive();
    drain("t3", 40);

    // Module 2 masked off: order 0,1,3,0 and module 2 never strobed.
    use4 = 1'b1; en_act = 4'b1011;
    clear_model();
    avail[0] = 8; avail[1] = 4; avail[2] = 4; avail[3] = 4;
    for (int k = 0; k < 4; k++) push(0, k);
    for (int k = 0; k < 4; k++) push(1, k);
    for (int k = 0; k < 4; k++) push(3, k);
    for (int k = 4; k < 8; k++) push(0, k);
    drive();
    n = 0; rdy2 = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      if (if4.in_ready[2]) rdy2++;
      n++;
    end
    chk("t4 in_ready2 cycles", LW'(rdy2), '0);
    drain("t4", 10);
    clear_model();
    drive();

    // Module 1 runs dry after 2 words, refills while module 2 holds the grant.
    use4 = 1'b0; en_act = 4'hF;
    clear_model();
    avail[0] = 2; avail[1] = 2; avail[2] = 3; avail[3] = 2;
    push(1, 0); push(1, 1);
    push(2, 0); push(2, 1); push(2, 2);
    push(3, 0); push(3, 1);
    push(0, 0); push(0, 1);
    push(1, 2); push(1, 3);
    drive();
    repeat (4) step();
    chk("t5 bubble after dry", LW'(if16.busy), '0);
    step();
    chk("t5 regrant after bubble", LW'(if16.busy), 1);
    step();
    avail[1] = 2;
    drive();
    drain("t5", 60);

    // Reset mid-burst with a word in the output register.
    use4 = 1'b0; en_act = 4'hF;
    clear_model();
    avail[0] = 10;
    push(0, 0);
    drive();
    repeat (3) step();
    chk("t6 out_valid before rst", LW'(if16.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6 rst out_valid", LW'(if16.out_valid), '0);
    chk("t6 rst in_ready", LW'(if16.in_ready), '0);
    chk("t6 rst busy", LW'(if16.busy), '0);
    repeat (2) step();
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < NM; i++) begin
      avail[i] = 1;
      push(i, 0);
    end
    drive();
    drain("t6", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
